// File: rtl/time_set_engine.sv
// BCD time-set engine: mirrors time_data while idle and lets the user edit HH:MM[:SS]
// with up/down keys, auto-repeat, a commit-on-timeout pulse and cancel.
module time_set_engine #(
    parameter int WITH_SEC     = 0,
    parameter int REPEAT_DELAY = 50,
    parameter int REPEAT_RATE  = 10,
    parameter int TIMEOUT      = 1000,
    localparam int DW          = (WITH_SEC != 0) ? 24 : 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          inc_min,
    input  logic          dec_min,
    input  logic          inc_hr,
    input  logic          dec_hr,
    input  logic          show_alarm,
    input  logic          show_time,
    input  logic [DW-1:0] time_data,
    input  logic [DW-1:0] alarm_data,
    output logic [DW-1:0] set_data,
    output logic          editing,
    output logic          commit
);

    localparam int HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int HW       = (HOLD_MAX > 1) ? $clog2(HOLD_MAX + 1) : 1;
    localparam int IW       = $clog2(TIMEOUT + 2);

    typedef enum logic {
        FOLLOW = 1'b0,
        EDIT   = 1'b1
    } state_t;

    state_t        state_q, state_d;
    logic [DW-1:0] data_q, data_d;
    logic [3:0]    prev_q, prev_d;
    logic [HW-1:0] hold_q, hold_d;
    logic [IW-1:0] idle_q, idle_d;
    logic          commit_q, commit_d;

    logic [3:0]    key_vec;
    logic          key_active;
    logic          key_first;
    logic          step;

    function automatic logic [7:0] bcd_clamp(input logic [7:0] v, input logic [7:0] max_v);
        if (v[7:4] > 4'd9 || v[3:0] > 4'd9 || v > max_v) return max_v;
        return v;
    endfunction

    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] max_v);
        if (v >= max_v) return 8'h00;
        if (v[3:0] == 4'd9) return {v[7:4] + 4'd1, 4'd0};
        return v + 8'd1;
    endfunction

    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] max_v);
        if (v == 8'h00) return max_v;
        if (v[3:0] == 4'd0) return {v[7:4] - 4'd1, 4'd9};
        return v - 8'd1;
    endfunction

    // Both fields are clamped first so a carry/borrow always lands on a legal hour.
    // Seconds (when present) are left at zero by every step.
    function automatic logic [DW-1:0] apply_step(input logic [DW-1:0] cur, input logic [3:0] key);
        logic [7:0]    hh;
        logic [7:0]    mm;
        logic [DW-1:0] res;
        hh  = bcd_clamp(cur[DW-1 -: 8], 8'h23);
        mm  = bcd_clamp(cur[DW-9 -: 8], 8'h59);
        res = '0;
        case (key)
            4'b0001: begin
                if (mm == 8'h59) begin
                    mm = 8'h00;
                    hh = bcd_inc(hh, 8'h23);
                end else begin
                    mm = bcd_inc(mm, 8'h59);
                end
            end
            4'b0010: begin
                if (mm == 8'h00) begin
                    mm = 8'h59;
                    hh = bcd_dec(hh, 8'h23);
                end else begin
                    mm = bcd_dec(mm, 8'h59);
                end
            end
            4'b0100: hh = bcd_inc(hh, 8'h23);
            4'b1000: hh = bcd_dec(hh, 8'h23);
            default: ;
        endcase
        res[DW-1 -: 8] = hh;
        res[DW-9 -: 8] = mm;
        return res;
    endfunction

    assign key_vec    = {dec_hr, inc_hr, dec_min, inc_min};
    assign key_active = $onehot(key_vec);
    assign key_first  = key_active && (key_vec != prev_q);
    assign step       = key_active && (key_first || hold_q == '0);

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        idle_d   = idle_q;
        commit_d = 1'b0;
        prev_d   = key_active ? key_vec : 4'b0000;

        // hold_q counts down to the next auto-repeat step while one key stays held
        if (!key_active)    hold_d = '0;
        else if (key_first) hold_d = HW'(REPEAT_DELAY - 1);
        else if (hold_q == '0) hold_d = HW'(REPEAT_RATE - 1);
        else                hold_d = hold_q - HW'(1);

        if (show_time) begin
            state_d = FOLLOW;
            data_d  = time_data;
            idle_d  = '0;
        end else if (show_alarm) begin
            state_d = EDIT;
            data_d  = alarm_data;
            idle_d  = '0;
        end else if (step) begin
            state_d = EDIT;
            data_d  = apply_step((state_q == FOLLOW) ? time_data : data_q, key_vec);
            idle_d  = '0;
        end else if (state_q == FOLLOW) begin
            data_d = time_data;
            idle_d = '0;
        end else if (TIMEOUT > 0 && idle_q == IW'(TIMEOUT)) begin
            // commit cycle has been shown; drop back to mirroring
            state_d = FOLLOW;
            data_d  = time_data;
            idle_d  = '0;
        end else if (key_active) begin
            idle_d = '0;
        end else if (TIMEOUT > 0) begin
            idle_d = idle_q + IW'(1);
            if (idle_q == IW'(TIMEOUT - 1)) commit_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= FOLLOW;
            data_q   <= '0;
            prev_q   <= '0;
            hold_q   <= '0;
            idle_q   <= '0;
            commit_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            prev_q   <= prev_d;
            hold_q   <= hold_d;
            idle_q   <= idle_d;
            commit_q <= commit_d;
        end
    end

    assign set_data = data_q;
    assign editing  = (state_q == EDIT);
    assign commit   = commit_q;

endmodule

// File: tb/tb_time_set_engine.sv
// Directed bench for time_set_engine: an HH:MM instance and an HH:MM:SS instance
// share the key inputs; expected values are hand-computed BCD constants.
module tb_time_set_engine;

    localparam logic [3:0] K_INC_MIN = 4'b0001;
    localparam logic [3:0] K_DEC_MIN = 4'b0010;
    localparam logic [3:0] K_INC_HR  = 4'b0100;
    localparam logic [3:0] K_DEC_HR  = 4'b1000;

    logic        clk = 1'b0;
    logic        reset;
    logic        inc_min, dec_min, inc_hr, dec_hr;
    logic        show_alarm, show_time;
    logic [15:0] time16, alarm16, set16;
    logic [23:0] time24, alarm24, set24;
    logic        edit16, commit16, edit24, commit24;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];

    time_set_engine #(
        .WITH_SEC(0), .REPEAT_DELAY(4), .REPEAT_RATE(2), .TIMEOUT(8)
    ) u_dut16 (
        .clk(clk), .reset(reset),
        .inc_min(inc_min), .dec_min(dec_min), .inc_hr(inc_hr), .dec_hr(dec_hr),
        .show_alarm(show_alarm), .show_time(show_time),
        .time_data(time16), .alarm_data(alarm16),
        .set_data(set16), .editing(edit16), .commit(commit16)
    );

    time_set_engine #(
        .WITH_SEC(1), .REPEAT_DELAY(4), .REPEAT_RATE(2), .TIMEOUT(8)
    ) u_dut24 (
        .clk(clk), .reset(reset),
        .inc_min(inc_min), .dec_min(dec_min), .inc_hr(inc_hr), .dec_hr(dec_hr),
        .show_alarm(show_alarm), .show_time(show_time),
        .time_data(time24), .alarm_data(alarm24),
        .set_data(set24), .editing(edit24), .commit(commit24)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_keys(input logic [3:0] k);
        {dec_hr, inc_hr, dec_min, inc_min} = k;
    endtask

    task automatic pulse(input logic [3:0] k);
        set_keys(k);
        tick();
        set_keys(4'b0000);
        tick();
    endtask

    task automatic load16(input logic [15:0] v);
        alarm16    = v;
        show_alarm = 1'b1;
        tick();
        show_alarm = 1'b0;
    endtask

    initial begin
        int ncommit;
        reset = 1'b1;
        set_keys(4'b0000);
        show_alarm = 1'b0;
        show_time  = 1'b0;
        time16  = 16'h2359;
        alarm16 = 16'h0000;
        time24  = 24'h125930;
        alarm24 = 24'h000000;
        tick();
        tick();

        check("reset_set16", set16, 16'h0000);
        check("reset_edit16", edit16, 1'b0);
        check("reset_commit16", commit16, 1'b0);
        check("reset_set24", set24, 24'h000000);

        reset = 1'b0;
        tick();
        check("follow_set16", set16, 16'h2359);
        check("follow_set24", set24, 24'h125930);
        check("follow_edit16", edit16, 1'b0);

        // increment with carry across midnight, starting from FOLLOW
        pulse(K_INC_MIN);
        check("inc_carry", set16, 16'h0000);
        check("inc_edit", edit16, 1'b1);
        check("sec_inc_min", set24, 24'h130000);
        pulse(K_INC_MIN);
        check("inc_again", set16, 16'h0001);

        // decrement across midnight
        load16(16'h0000);
        check("load_alarm", set16, 16'h0000);
        pulse(K_DEC_MIN);
        check("dec_min_wrap", set16, 16'h2359);
        pulse(K_DEC_HR);
        check("dec_hr", set16, 16'h2259);
        for (int i = 0; i < 22; i++) pulse(K_DEC_HR);
        check("dec_hr_x22", set16, 16'h0059);
        pulse(K_DEC_HR);
        check("dec_hr_wrap", set16, 16'h2359);
        pulse(K_INC_HR);
        check("inc_hr_wrap", set16, 16'h0059);

        // hour digit carry / borrow, minutes untouched
        load16(16'h0915);
        pulse(K_INC_HR);
        check("inc_hr_carry", set16, 16'h1015);
        pulse(K_DEC_HR);
        check("dec_hr_borrow", set16, 16'h0915);

        // illegal loaded value is clamped before stepping
        load16(16'h2575);
        pulse(K_DEC_HR);
        check("clamp_dec_hr", set16, 16'h2259);
        load16(16'h2575);
        pulse(K_INC_MIN);
        check("clamp_inc_min", set16, 16'h0000);

        // auto-repeat: steps at cycles 0,4,6,8,10
        load16(16'h1000);
        exp_q = {16'h1001, 16'h1001, 16'h1001, 16'h1001, 16'h1002, 16'h1002,
                 16'h1003, 16'h1003, 16'h1004, 16'h1004, 16'h1005};
        set_keys(K_INC_MIN);
        for (int i = 0; i < 11; i++) begin
            tick();
            check($sformatf("repeat_c%0d", i), set16, exp_q.pop_front());
        end
        set_keys(4'b0000);
        tick();
        check("repeat_release", set16, 16'h1005);
        set_keys(K_INC_MIN);
        tick();
        check("repress", set16, 16'h1006);
        set_keys(4'b0000);
        tick();

        // conflicting keys give no step; dropping one gives exactly one step
        set_keys(K_INC_MIN | K_INC_HR);
        for (int i = 0; i < 5; i++) begin
            tick();
            check($sformatf("conflict_c%0d", i), set16, 16'h1006);
        end
        set_keys(K_INC_MIN);
        tick();
        check("conflict_drop", set16, 16'h1007);
        tick();
        check("conflict_one_step", set16, 16'h1007);
        set_keys(4'b0000);

        // timeout commit after 8 idle cycles
        time16 = 16'h0815;
        for (int i = 0; i < 7; i++) tick();
        check("timeout_early", commit16, 1'b0);
        tick();
        check("timeout_commit", commit16, 1'b1);
        check("timeout_hold", set16, 16'h1007);
        check("timeout_edit", edit16, 1'b1);
        tick();
        check("timeout_pulse_end", commit16, 1'b0);
        check("timeout_exit", edit16, 1'b0);
        check("timeout_follow", set16, 16'h0815);
        time16 = 16'h0816;
        tick();
        check("follow_track", set16, 16'h0816);

        // cancel mid-edit
        load16(16'h1200);
        pulse(K_INC_HR);
        check("cancel_pre", set16, 16'h1300);
        show_time = 1'b1;
        tick();
        show_time = 1'b0;
        check("cancel_set", set16, 16'h0816);
        check("cancel_edit", edit16, 1'b0);
        ncommit = 0;
        for (int i = 0; i < 12; i++) begin
            if (commit16) ncommit++;
            tick();
        end
        check("cancel_no_commit", ncommit, 0);

        // asynchronous reset during auto-repeat
        time16 = 16'h1111;
        set_keys(K_INC_MIN);
        for (int i = 0; i < 5; i++) tick();
        check("rst_pre", set16, 16'h1113);
        #2;
        reset = 1'b1;
        #1;
        check("rst_async_set", set16, 16'h0000);
        check("rst_async_edit", edit16, 1'b0);
        check("rst_async_commit", commit16, 1'b0);
        set_keys(4'b0000);
        tick();
        reset = 1'b0;
        tick();
        check("rst_follow", set16, 16'h1111);

        // seconds field cleared by minute steps
        check("sec_follow", set24, 24'h125930);
        pulse(K_INC_MIN);
        check("sec_inc_min2", set24, 24'h130000);
        pulse(K_DEC_MIN);
        check("sec_dec_min", set24, 24'h125900);

        // final report
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/time_set_engine.md
Name: time_set_engine

Overview:
- Parametrised successor to the alarm clock's time-set counter. Holds an HH:MM[:SS] BCD value that the user edits with up/down minute and hour keys.
- Adds decrement, held-key auto-repeat, optional seconds field, edit timeout with commit pulse, and cancel.
- Sits between the debounced key inputs and the time/alarm registers. When not editing, it mirrors time_data to the display path.

Parameters:
- WITH_SEC, 0, 1 adds an SS field (DW=24), 0 gives HH:MM (DW=16).
- REPEAT_DELAY, 50, cycles from first step to first auto-repeat step while a key stays held (>=1).
- REPEAT_RATE, 10, cycles between subsequent auto-repeat steps (>=1).
- TIMEOUT, 1000, idle cycles in EDIT before commit. 0 disables timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- inc_min  in  1  minute-up key (level, debounced)
- dec_min  in  1  minute-down key
- inc_hr  in  1  hour-up key
- dec_hr  in  1  hour-down key
- show_alarm  in  1  load alarm_data and enter EDIT
- show_time  in  1  cancel edit, return to FOLLOW
- time_data  in  DW  current time, BCD {HH,MM[,SS]}
- alarm_data  in  DW  current alarm, BCD
- set_data  out  DW  edited/mirrored value, BCD
- editing  out  1  high in EDIT
- commit  out  1  one-cycle pulse when an edit completes by timeout

Behaviour:
- Reset (async, high): state=FOLLOW, set_data=0, editing=0, commit=0; all counters=0.
- States:
  - FOLLOW: set_data<=time_data every cycle.
  - EDIT: set_data holds except on steps and loads.
- Priority each cycle: show_time > show_alarm > key step.
  - show_time: state->FOLLOW, set_data<=time_data, no commit (cancel).
  - show_alarm: state->EDIT, set_data<=alarm_data, idle counter cleared.
- Key qualification: exactly one of the four keys high = active key. Zero or more than one = none; this clears the hold counter and registered previous-key state.
- Step timing: all steps take effect at the clock edge where the condition is seen; registered outputs update one cycle after sampling.
  - First step: active key high and previous-cycle active key differs. From FOLLOW, the step operates on the current time_data and state->EDIT.
  - Auto-repeat: key held continuously; steps at REPEAT_DELAY cycles after the first step, then every REPEAT_RATE cycles. Release or key change restarts the sequence.
- Minute step:
  - Any minute step clears SS to 00 (WITH_SEC=1).
  - inc: MM+1 with BCD digit carry; 59->00 with hour+1; 23:59->00:00.
  - dec: MM-1; 00->59 with hour-1; 00:00->23:59.
- Hour step:
  - Any hour step clears SS to 00 (WITH_SEC=1).
  - inc: 23->00, x9->(x+1)0, minutes unchanged.
  - dec: 00->23, x0->(x-1)9, minutes unchanged.
- BCD rules:
  - Every output digit stays legal: HH 00-23, MM/SS 00-59.
  - If an illegal value is loaded, the next step first clamps that field to its maximum, then applies the step.
- Timeout:
  - In EDIT, the idle counter increments each cycle with no active key and no load. Any step or load clears it.
  - When idle reaches TIMEOUT (TIMEOUT>0): commit=1 for exactly that cycle, set_data holds the edited value in that cycle, state->FOLLOW next cycle.
- Reset mid-edit or mid-repeat: immediate return to reset values, no commit.

Test Plan:
- Inc minute with carry: reset, time_data=16'h2359, pulse inc_min 1 cycle -> set_data=16'h0000, editing=1. Pulse inc_min again -> 16'h0001.
- Dec across midnight: show_alarm with alarm_data=16'h0000, then pulse dec_min -> 16'h2359. Pulse dec_hr -> 16'h2259. Pulse dec_hr x22 -> 16'h0059 then 16'h2359.
- Auto-repeat (REPEAT_DELAY=4, REPEAT_RATE=2): from 16'h1000 hold inc_min 11 cycles -> steps at cycles 0,4,6,8,10 give 16'h1005. Release and re-press -> 16'h1006 on the first cycle.
- Conflicting keys: inc_min and inc_hr high together for 5 cycles -> set_data unchanged, no step. Drop inc_hr -> exactly one step on the next edge.
- Timeout commit (TIMEOUT=8): after the last step, idle 8 cycles -> commit high for exactly 1 cycle, set_data=edited value. Next cycle editing=0 and set_data tracks time_data.
- Cancel, reset and seconds (WITH_SEC=1):
  - show_time mid-edit -> no commit, set_data=time_data.
  - Assert reset during repeat -> set_data=0 asynchronously.
  - Inc_min on 24'h125930 -> 24'h130000.
